// File: rtl/alu_cmd_initiator.sv
// alu_cmd_initiator
//   Accepts tagged ALU commands over a valid/ready handshake and buffers them
//   in a small FIFO. It drives one command at a time onto the combinational
//   ALU, waits SETTLE_CYCLES, and captures the result. The result goes back
//   downstream with its tag and opcode over a second valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH    command FIFO entries (power of two, >= 2)
//   SETTLE_CYCLES cycles from driving alu_* to sampling alu_result (0 -> 1)
//   TAG_W         command/response tag width
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          upstream handshake; cmd_a, cmd_b, cmd_op, cmd_tag
//   alu_a, alu_b, alu_opcode     driven to the ALU, change only on a FIFO pop
//   alu_result                   ALU output, sampled at the end of settle
//   rsp_valid/rsp_ready          downstream handshake; rsp_result, rsp_op, rsp_tag
//   busy                         FSM not idle or FIFO non-empty
//   op_count                     completed responses (wraps)
//   mismatch, err_count          self-check flag/count (tied to 0 unless
//                                ALU_SELFCHECK_EN is defined)
//
// Optional feature macro: ALU_SELFCHECK_EN
module alu_cmd_initiator #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [4:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_result,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic             mismatch,
    output logic [7:0]       err_count
);

    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW         = $clog2(SETTLE_EFF + 1);
    localparam int EW         = TAG_W + 10;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t state, state_nx;

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [EW-1:0]    head;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    cnt;
    logic             capture, handshake;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign capture   = (state == SETTLE) && (cnt == CW'(1));
    assign handshake = (state == RESP) && rsp_ready;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {cmd_tag, cmd_op, cmd_b, cmd_a};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty)  state_nx = SETTLE;
            SETTLE:  if (capture) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_tag    <= '0;
            op_count   <= '0;
        end else begin
            if (pop) begin
                {tag_q, alu_opcode, alu_b, alu_a} <= head;
                cnt <= CW'(SETTLE_EFF);
            end
            if (state == SETTLE)
                cnt <= cnt - CW'(1);
            if (capture) begin
                rsp_result <= alu_result;
                rsp_op     <= alu_opcode;
                rsp_tag    <= tag_q;
                rsp_valid  <= 1'b1;
            end
            if (handshake) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 16'd1;
            end
        end
    end

`ifdef ALU_SELFCHECK_EN
    logic [4:0] exp_result;

    always_comb begin
        exp_result = '0;
        case (alu_opcode)
            2'b00: exp_result = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01: exp_result = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10: exp_result = {1'b0, alu_a & alu_b};
            2'b11: exp_result = {1'b0, alu_a | alu_b};
            default: exp_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (capture) begin
            mismatch <= (alu_result != exp_result);
            if ((alu_result != exp_result) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end else if (handshake) begin
            mismatch <= 1'b0;
        end
    end
`else
    assign mismatch  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_initiator.sv
module tb_alu_cmd_initiator;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_a, cmd_b;
    logic [1:0]    cmd_op;
    logic [TW-1:0] cmd_tag;
    logic [3:0]    alu_a, alu_b;
    logic [1:0]    alu_opcode;
    logic [4:0]    alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [4:0]    rsp_result;
    logic [1:0]    rsp_op;
    logic [TW-1:0] rsp_tag;
    logic          busy;
    logic [15:0]   op_count;
    logic          mismatch;
    logic [7:0]    err_count;

    int checks   = 0;
    int failures = 0;
    logic          bad_alu = 1'b0;
    logic [10:0]   sb [$];

    alu_cmd_initiator #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .busy(busy), .op_count(op_count),
        .mismatch(mismatch), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Combinational ALU model; bad_alu forces a wrong (zero) result.
    always_comb alu_result = bad_alu ? 5'd0 : alu_ref(alu_a, alu_b, alu_opcode);

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Response monitor: a handshake completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL rsp_unexpected observed=%0h expected=none",
                       {rsp_result, rsp_op, rsp_tag});
            end else begin
                chk("rsp_data", {21'd0, rsp_result, rsp_op, rsp_tag}, {21'd0, sb.pop_front()});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [TW-1:0] tag);
        logic [4:0] r;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                r = bad_alu ? 5'd0 : alu_ref(a, b, op);
                sb.push_back({r, op, tag});
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $error("FAIL push_timeout observed=cmd_ready_low expected=accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int unsigned i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && sb.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++;
        failures++;
        $error("FAIL drain_timeout observed=busy expected=idle");
    endtask

    logic [22:0] snap;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_tag = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
        chk("rst_rsp", {rsp_result, rsp_op, rsp_tag}, 0);
        chk("rst_selfcheck", {mismatch, err_count}, 0);

        // Single op with latency check
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push(4'd7, 4'd9, 2'b00, 4'd3);
        @(negedge clk);
        chk("lat_n0_valid", rsp_valid, 0);
        chk("lat_n0_busy", busy, 1);
        @(negedge clk);
        chk("lat_n1_valid", rsp_valid, 0);
        chk("lat_n1_alu", {alu_a, alu_b, alu_opcode}, {4'd7, 4'd9, 2'b00});
        @(negedge clk);
        chk("lat_n2_valid", rsp_valid, 1);
        chk("single_result", rsp_result, 5'b10000);
        chk("single_tag", rsp_tag, 3);
        @(negedge clk);
        chk("single_op_count", op_count, 1);
        chk("single_valid_drop", rsp_valid, 0);
        @(posedge clk); #1;

        // Arithmetic sweep, tags 0..3 in order
        push(4'd2, 4'd5, 2'b01, 4'd0);
        push(4'hC, 4'hA, 2'b10, 4'd1);
        push(4'hC, 4'd3, 2'b11, 4'd2);
        push(4'hF, 4'hF, 2'b00, 4'd3);
        wait_idle();
        chk("sweep_op_count", op_count, 5);
        chk("idle_alu_hold", {alu_a, alu_b, alu_opcode}, {4'hF, 4'hF, 2'b00});

        // Backpressure: 5 accepted, 6th held off
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++)
            push(4'(i + 1), 4'(i + 3), 2'(i), 4'(i + 4));
        cmd_a = 4'hE; cmd_b = 4'h1; cmd_op = 2'b01; cmd_tag = 4'd9; cmd_valid = 1'b1;
        @(negedge clk);
        snap = {rsp_valid, rsp_result, rsp_op, rsp_tag, alu_a, alu_b, alu_opcode};
        chk("bp_rsp_valid", rsp_valid, 1);
        for (int unsigned i = 0; i < 6; i++) begin
            chk("bp_cmd_ready_low", cmd_ready, 0);
            chk("bp_stable", {rsp_valid, rsp_result, rsp_op, rsp_tag, alu_a, alu_b, alu_opcode}, snap);
            @(negedge clk);
        end
        chk("bp_op_count", op_count, 5);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push(4'hE, 4'h1, 2'b01, 4'd9);
        push(4'h8, 4'h8, 2'b00, 4'd10);
        push(4'h5, 4'h6, 2'b01, 4'd11);
        push(4'h9, 4'h6, 2'b11, 4'd12);
        wait_idle();
        chk("bp_drain_op_count", op_count, 14);

        // Reset during SETTLE with 3 commands queued
        for (int unsigned i = 0; i < 5; i++)
            push(4'(i), 4'(i + 1), 2'b00, 4'(i));
        chk("pre_rst_valid", rsp_valid, 0);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_op_count", op_count, 0);
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", {rsp_valid, busy}, 0);
        end
        @(posedge clk); #1;
        push(4'h3, 4'h9, 2'b01, 4'd7);
        wait_idle();
        chk("post_rst_op_count", op_count, 1);
        chk("selfcheck_clean", {mismatch, err_count}, 0);

`ifdef ALU_SELFCHECK_EN
        rsp_ready = 1'b0;
        bad_alu = 1'b1;
        push(4'd1, 4'd1, 2'b00, 4'd5);
        for (int unsigned i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("sc_rsp_valid", rsp_valid, 1);
        chk("sc_mismatch_set", mismatch, 1);
        chk("sc_err_count", err_count, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();
        bad_alu = 1'b0;
        chk("sc_mismatch_clr", mismatch, 0);
        rsp_ready = 1'b0;
        push(4'd3, 4'd4, 2'b00, 4'd6);
        for (int unsigned i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("sc_good_valid", rsp_valid, 1);
        chk("sc_good_mismatch", mismatch, 0);
        chk("sc_good_err", err_count, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();
        chk("sc_op_count", op_count, 3);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
